// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: fetches from internal imem, holds each word for
// HOLD_CYCLES cycles, then advances PC. Define IFU_BRANCH_EN to enable j/beq.
module instr_fetch_unit #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned IMEM_AW     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_we,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [31:0]        load_data,
  input  logic               br_eq,
  output logic [31:0]        instrword,
  output logic               newinstr,
  output logic [31:0]        pc,
  output logic               busy,
  output logic               halt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t             state, state_next;
  logic [3:0]         hold_cnt;
  logic [31:0]        imem [0:(1<<IMEM_AW)-1];
  logic [31:0]        pc_plus4;
  logic [31:0]        pc_next;
  logic               last_hold;
  logic               halt_word;
  logic               mem_wr;
  logic [IMEM_AW-1:0] fetch_idx;

  assign pc_plus4  = pc + 32'd4;
  assign last_hold = (state == HOLD) && (hold_cnt == 4'(HOLD_CYCLES - 1));
  assign halt_word = (instrword == '1);
  assign mem_wr    = load_we && ((state == IDLE) || (state == HALT));
  assign fetch_idx = pc[IMEM_AW+1:2];

`ifdef IFU_BRANCH_EN
  always_comb begin
    pc_next = pc_plus4;
    case (instrword[31:26])
      6'd2: pc_next = {pc_plus4[31:28], instrword[25:0], 2'b00};
      6'd4: if (br_eq) pc_next = pc_plus4 + {{14{instrword[15]}}, instrword[15:0], 2'b00};
      default: ;
    endcase
  end
`else
  logic unused_br_eq;
  assign unused_br_eq = br_eq;
  assign pc_next      = pc_plus4;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = HOLD;
      HOLD:    if (last_hold) state_next = halt_word ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FETCH) || (state == HOLD);
    halt = (state == HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= '0;
      instrword <= '0;
      newinstr  <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      newinstr <= 1'b0;
      case (state)
        FETCH: begin
          instrword <= imem[fetch_idx];
          newinstr  <= 1'b1;
          hold_cnt  <= '0;
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 4'd1;
          // halt marker keeps pc on the halting instruction
          if (last_hold && !halt_word) pc <= pc_next;
        end
        default: ;
      endcase
    end
  end

  // memory has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (rst && mem_wr) imem[load_addr] <= load_data;
  end

endmodule
